// File: rtl/instr_executor.sv
// Sequential instruction executor: fetches a wrapping range of instruction-register
// locations and streams one signed result per location. INSTR_EXEC_DIVMOD_EN enables DIV/MOD.

package instr_executor_pkg;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned OPC_W  = 4;
  localparam int unsigned OP_W   = 32;

  typedef logic [ADDR_W-1:0] address_t;

  typedef struct packed {
    logic [OPC_W-1:0]       opc;
    logic signed [OP_W-1:0] op_a;
    logic signed [OP_W-1:0] op_b;
  } instruction_t;

  typedef enum logic [OPC_W-1:0] {
    OPC_ZERO  = 4'd0,
    OPC_PASSA = 4'd1,
    OPC_PASSB = 4'd2,
    OPC_ADD   = 4'd3,
    OPC_SUB   = 4'd4,
    OPC_MULT  = 4'd5,
    OPC_DIV   = 4'd6,
    OPC_MOD   = 4'd7
  } opcode_e;
endpackage

module instr_executor
  import instr_executor_pkg::*;
#(
  parameter int unsigned RES_W = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  address_t                first_ptr,
  input  address_t                last_ptr,
  output address_t                read_pointer,
  input  instruction_t            instruction_word,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic signed [RES_W-1:0] res_data,
  output address_t                res_addr,
  output logic                    res_err,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    OUT   = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e       state, state_next;
  address_t     ptr, ptr_next;
  address_t     end_ptr, end_ptr_next;
  instruction_t instr_q;

  logic signed [RES_W-1:0] a_ext, b_ext, calc_data;
  logic                    calc_err;

  // Next-state and range-pointer logic
  always_comb begin
    state_next   = state;
    ptr_next     = ptr;
    end_ptr_next = end_ptr;
    case (state)
      IDLE: begin
        if (start) begin
          ptr_next     = first_ptr;
          end_ptr_next = last_ptr;
          state_next   = FETCH;
        end
      end
      FETCH: state_next = EXEC;
      EXEC:  state_next = OUT;
      OUT: begin
        if (res_ready) begin
          if (ptr == end_ptr) begin
            state_next = DONE;
          end else begin
            ptr_next   = ptr + address_t'(1);
            state_next = FETCH;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operands widened with sign so products and quotients cannot overflow
  assign a_ext = {{(RES_W-OP_W){instr_q.op_a[OP_W-1]}}, instr_q.op_a};
  assign b_ext = {{(RES_W-OP_W){instr_q.op_b[OP_W-1]}}, instr_q.op_b};

  // Result computation from the captured instruction
  always_comb begin
    calc_data = '0;
    calc_err  = 1'b0;
    case (instr_q.opc)
      OPC_ZERO:  calc_data = '0;
      OPC_PASSA: calc_data = a_ext;
      OPC_PASSB: calc_data = b_ext;
      OPC_ADD:   calc_data = a_ext + b_ext;
      OPC_SUB:   calc_data = a_ext - b_ext;
      OPC_MULT:  calc_data = a_ext * b_ext;
`ifdef INSTR_EXEC_DIVMOD_EN
      OPC_DIV: begin
        if (b_ext == '0) calc_err  = 1'b1;
        else             calc_data = a_ext / b_ext;
      end
      OPC_MOD: begin
        if (b_ext == '0) calc_err  = 1'b1;
        else             calc_data = a_ext % b_ext;
      end
`endif
      default:   calc_err = 1'b1;
    endcase
  end

  // State, datapath and registered outputs (status outputs follow the next state)
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      ptr          <= '0;
      end_ptr      <= '0;
      instr_q      <= '0;
      read_pointer <= '0;
      res_valid    <= 1'b0;
      res_data     <= '0;
      res_addr     <= '0;
      res_err      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state     <= state_next;
      ptr       <= ptr_next;
      end_ptr   <= end_ptr_next;
      busy      <= (state_next != IDLE);
      res_valid <= (state_next == OUT);
      done      <= (state_next == DONE);
      if (state_next == FETCH) read_pointer <= ptr_next;
      if (state == FETCH)      instr_q      <= instruction_word;
      if (state == EXEC) begin
        res_data <= calc_data;
        res_addr <= ptr;
        res_err  <= calc_err;
      end
    end
  end

endmodule

// File: tb/tb_instr_executor.sv
// Directed bench for instr_executor: queue-based result model checked every cycle,
// plus hand-computed expectations for the key scenarios.

module tb_instr_executor;
  import instr_executor_pkg::*;

  localparam int unsigned RES_W = 64;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    start = 1'b0;
  logic                    res_ready = 1'b0;
  address_t                first_ptr = '0;
  address_t                last_ptr = '0;
  address_t                read_pointer;
  address_t                res_addr;
  instruction_t            instruction_word;
  logic                    res_valid, res_err, busy, done;
  logic signed [RES_W-1:0] res_data;

  instruction_t mem [32];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign instruction_word = mem[read_pointer];

  instr_executor #(.RES_W(RES_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .first_ptr        (first_ptr),
    .last_ptr         (last_ptr),
    .read_pointer     (read_pointer),
    .instruction_word (instruction_word),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_data         (res_data),
    .res_addr         (res_addr),
    .res_err          (res_err),
    .busy             (busy),
    .done             (done)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, $signed(act), $signed(exp), $time);
    end
  endtask

  function automatic instruction_t mk(input logic [3:0] o, input int a, input int b);
    instruction_t w;
    w.opc  = o;
    w.op_a = a;
    w.op_b = b;
    return w;
  endfunction

  // Reference result of one instruction, in plain 64-bit integer arithmetic
  function automatic void model_res(input instruction_t w, output longint d, output bit e);
    longint a, b;
    a = $signed(w.op_a);
    b = $signed(w.op_b);
    d = 0;
    e = 1'b0;
    case (w.opc)
      4'd0: d = 0;
      4'd1: d = a;
      4'd2: d = b;
      4'd3: d = a + b;
      4'd4: d = a - b;
      4'd5: d = a * b;
      4'd6, 4'd7: begin
`ifdef INSTR_EXEC_DIVMOD_EN
        if (b == 0)           e = 1'b1;
        else if (w.opc == 4'd6) d = a / b;
        else                  d = a % b;
`else
        e = 1'b1;
`endif
      end
      default: e = 1'b1;
    endcase
  endfunction

  typedef struct {
    longint   d;
    bit       e;
    address_t a;
  } exp_t;

  exp_t m_q[$];
  bit   m_ok = 1'b0;
  bit   m_active = 1'b0;
  bit   m_valid = 1'b0;
  bit   m_done = 1'b0;
  int   m_cnt = 0;

  // Transaction model: range expands to a queue; results appear in the third cycle after
  // the start sample or the previous accept; done lasts one cycle after the final accept.
  initial forever begin
    @(posedge clk);
    if (reset) begin
      m_ok = 1'b1; m_active = 1'b0; m_valid = 1'b0; m_done = 1'b0; m_cnt = 0;
      m_q.delete();
    end else if (m_done) begin
      m_done = 1'b0;
      m_active = 1'b0;
    end else if (!m_active) begin
      if (start) begin
        address_t a;
        exp_t x;
        a = first_ptr;
        for (int i = 0; i < 32; i++) begin
          model_res(mem[a], x.d, x.e);
          x.a = a;
          m_q.push_back(x);
          if (a == last_ptr) break;
          a = a + 5'd1;
        end
        m_active = 1'b1;
        m_valid  = 1'b0;
        m_cnt    = 2;
      end
    end else if (m_valid) begin
      if (res_ready) begin
        void'(m_q.pop_front());
        m_valid = 1'b0;
        if (m_q.size() == 0) m_done = 1'b1;
        else                 m_cnt  = 2;
      end
    end else begin
      m_cnt--;
      if (m_cnt == 0) m_valid = 1'b1;
    end
  end

  // Per-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (m_ok) begin
      check("busy", busy, m_active);
      check("res_valid", res_valid, m_valid);
      check("done", done, m_done);
      if (m_valid && m_q.size() > 0) begin
        check("res_data", res_data, m_q[0].d);
        check("res_addr", res_addr, m_q[0].a);
        check("res_err", res_err, m_q[0].e);
      end
    end
  end

  task automatic do_start(input address_t f, input address_t l);
    @(negedge clk);
    start = 1'b1;
    first_ptr = f;
    last_ptr = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input string nm, output int waited);
    waited = 0;
    while (!res_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check(nm, res_valid, 1'b1);
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(nm, done, 1'b1);
  endtask

  initial begin
    int     w;
    longint exp_div, exp_mod;
    bit     exp_dm_err;
    int     exp_addr [4];

    for (int i = 0; i < 32; i++) mem[i] = mk(OPC_ZERO, 0, 0);
    mem[0]  = mk(OPC_ADD, 7, -3);
    mem[1]  = mk(OPC_MULT, -5, 6);
    mem[2]  = mk(OPC_SUB, 2, 9);
    mem[3]  = mk(OPC_DIV, -7, 2);
    mem[4]  = mk(OPC_MOD, -7, 2);
    mem[5]  = mk(OPC_DIV, 5, 0);
    mem[6]  = mk(OPC_ZERO, 11, 12);
    mem[7]  = mk(4'd9, 1, 1);
    mem[30] = mk(OPC_PASSA, 100, 1);
    mem[31] = mk(OPC_PASSB, 3, -8);

`ifdef INSTR_EXEC_DIVMOD_EN
    exp_div = -3; exp_mod = -1; exp_dm_err = 1'b0;
`else
    exp_div = 0;  exp_mod = 0;  exp_dm_err = 1'b1;
`endif
    exp_addr[0] = 30; exp_addr[1] = 31; exp_addr[2] = 0; exp_addr[3] = 1;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_read_pointer", read_pointer, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_addr", res_addr, 0);
    check("rst_res_err", res_err, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b0;
    res_ready = 1'b1;

    // Single location: ADD 7 + -3; valid shows two cycles after the post-start cycle
    do_start(5'd0, 5'd0);
    wait_valid("t1_valid", w);
    check("t1_latency", w, 2);
    check("t1_data", res_data, 4);
    check("t1_addr", res_addr, 0);
    check("t1_err", res_err, 0);
    wait_done("t1_done");
    @(negedge clk);
    check("t1_done_one_cycle", done, 0);
    check("t1_idle", busy, 0);

    // Two locations back to back with res_ready held
    do_start(5'd1, 5'd2);
    wait_valid("t2_valid0", w);
    check("t2_data0", res_data, -30);
    check("t2_addr0", res_addr, 1);
    @(negedge clk);
    wait_valid("t2_valid1", w);
    check("t2_latency1", w, 2);
    check("t2_data1", res_data, -7);
    check("t2_addr1", res_addr, 2);
    wait_done("t2_done");

    // Stall in OUT with a stray start pulse; DIV/MOD results
    res_ready = 1'b0;
    do_start(5'd3, 5'd4);
    wait_valid("t3_valid", w);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 1) begin start = 1'b1; first_ptr = 5'd10; last_ptr = 5'd10; end
      if (k == 2) start = 1'b0;
      check("t3_stall_valid", res_valid, 1);
      check("t3_stall_data", res_data, exp_div);
      check("t3_stall_addr", res_addr, 3);
      check("t3_stall_err", res_err, exp_dm_err);
    end
    res_ready = 1'b1;
    @(negedge clk);
    wait_valid("t3_valid_mod", w);
    check("t3_mod_data", res_data, exp_mod);
    check("t3_mod_err", res_err, exp_dm_err);
    wait_done("t3_done");

    // Divide by zero, ZERO opcode, unsupported opcode
    do_start(5'd5, 5'd7);
    wait_valid("t4_valid", w);
    check("t4_div0_data", res_data, 0);
    check("t4_div0_err", res_err, 1);
    wait_done("t4_done");

    // Wrapping range 30..1
    do_start(5'd30, 5'd1);
    for (int k = 0; k < 4; k++) begin
      wait_valid("t5_valid", w);
      check("t5_addr", res_addr, exp_addr[k]);
      if (k == 0) check("t5_passa", res_data, 100);
      if (k == 1) check("t5_passb", res_data, -8);
      @(negedge clk);
    end
    wait_done("t5_done");

    // Reset during EXEC, with start asserted in the same cycle
    do_start(5'd0, 5'd2);
    @(negedge clk);
    check("t6_busy_exec", busy, 1);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check("t6_busy", busy, 0);
    check("t6_valid", res_valid, 0);
    check("t6_done", done, 0);
    reset = 1'b0;
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t6_no_done", done, 0);
      check("t6_stay_idle", busy, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
